mem_port_arbiter: RTL and testbench

Shares one single-ported, variable-latency memory between the CPU's instruction-fetch path and its load/store path. The block sits between the pipelined core and a unified memory. It serialises the two requesters onto a request/acknowledge memory handshake and returns data with a one-cycle valid pulse. It also drives a stall that freezes the pipeline while any request is outstanding. Data accesses normally win arbitration, and a starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one variable-latency memory port.
// Optional watchdog abort is built when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_valid,
  input  logic        i_d_rd_en,
  input  logic        i_d_wr_en,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [2:0]  i_d_type,
  output logic [31:0] o_d_rdata,
  output logic        o_d_valid,
  output logic        o_cpu_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [2:0]  o_mem_type,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [3:0] LP_STARVE = 4'(STARVE_LIMIT);

  generate
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_cfg
      $error("mem_port_arbiter: STARVE_LIMIT or TIMEOUT out of range");
    end
  endgenerate

  state_t      r_state;
  logic [3:0]  r_fetch_wait;
  logic [31:0] r_if_rdata;
  logic        r_if_valid;
  logic [31:0] r_d_rdata;
  logic        r_d_valid;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [2:0]  r_mem_type;
  logic        r_bus_err;

  logic        w_d_pend;
  logic        w_data_win;
  logic [3:0]  w_fw_inc;
  logic        w_tmo;

  assign w_d_pend   = i_d_rd_en | i_d_wr_en;
  // A saturated counter with no fetch waiting must not lock out data.
  assign w_data_win = w_d_pend & ((r_fetch_wait < LP_STARVE) | ~i_if_req);
  assign w_fw_inc   = (i_if_req && (r_fetch_wait != 4'hF)) ? (r_fetch_wait + 4'd1) : r_fetch_wait;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_tmo_cnt;

  assign w_tmo = (r_tmo_cnt == LP_TMO_LAST);

  // Watchdog: counts busy cycles since the last grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmo_cnt <= 8'd0;
    end else if (r_state == ST_IDLE) begin
      r_tmo_cnt <= 8'd0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Arbitration FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_fetch_wait <= 4'd0;
      r_if_rdata   <= 32'd0;
      r_if_valid   <= 1'b0;
      r_d_rdata    <= 32'd0;
      r_d_valid    <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_type   <= 3'd0;
      r_bus_err    <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_data_win) begin
            r_state      <= ST_DATA;
            r_fetch_wait <= w_fw_inc;
            r_mem_req    <= 1'b1;
            r_mem_we     <= i_d_wr_en;
            r_mem_addr   <= i_d_addr;
            r_mem_wdata  <= i_d_wdata;
            r_mem_type   <= i_d_type;
          end else if (i_if_req) begin
            r_state      <= ST_FETCH;
            r_fetch_wait <= 4'd0;
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= i_if_addr;
            r_mem_wdata  <= 32'd0;
            r_mem_type   <= 3'b010;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FETCH, ST_DATA: begin
          if (i_mem_ack || w_tmo) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_type  <= 3'd0;
            r_bus_err   <= ~i_mem_ack;
            if (r_state == ST_FETCH) begin
              r_if_valid <= 1'b1;
              if (i_mem_ack) begin
                r_if_rdata <= i_mem_rdata;
              end else begin
                r_if_rdata <= r_if_rdata;
              end
            end else begin
              r_d_valid <= 1'b1;
              if (i_mem_ack && !r_mem_we) begin
                r_d_rdata <= i_mem_rdata;
              end else begin
                r_d_rdata <= r_d_rdata;
              end
            end
          end else begin
            r_state <= r_state;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_if_rdata  = r_if_rdata;
  assign o_if_valid  = r_if_valid;
  assign o_d_rdata   = r_d_rdata;
  assign o_d_valid   = r_d_valid;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_type  = r_mem_type;
  assign o_bus_err   = r_bus_err;
  assign o_cpu_stall = ~i_rst & ((i_if_req & ~r_if_valid) | (w_d_pend & ~r_d_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (honours ARB_TIMEOUT_EN if defined).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_rd_en;
  logic        d_wr_en;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_type;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_type;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int n_asserts = 0;
  int n_fail    = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_valid(if_valid),
    .i_d_rd_en(d_rd_en), .i_d_wr_en(d_wr_en), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .i_d_type(d_type), .o_d_rdata(d_rdata), .o_d_valid(d_valid), .o_cpu_stall(cpu_stall),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_type(mem_type), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int     li;
    int     cnt;
    logic   is_f;
    logic [31:0] exp_addr;

    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_rd_en = 1'b0; d_wr_en = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; d_type = 3'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    rst = 1'b0;

    // Single fetch, memory acks on the first request cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0100;
    @(negedge clk);
    chk("f_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'h0000_0100);
    chk("f_mem_we", {31'd0, mem_we}, 32'd0);
    chk("f_stall_busy", {31'd0, cpu_stall}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    chk("f_if_valid", {31'd0, if_valid}, 32'd1);
    chk("f_if_rdata", if_rdata, 32'h0050_0093);
    chk("f_mem_req_drop", {31'd0, mem_req}, 32'd0);
    chk("f_stall_pulse", {31'd0, cpu_stall}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    chk("f_if_valid_end", {31'd0, if_valid}, 32'd0);
    chk("f_if_rdata_hold", if_rdata, 32'h0050_0093);
    chk("f_stall_after", {31'd0, cpu_stall}, 32'd0);

    // Stray ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_if_valid", {31'd0, if_valid}, 32'd0);
    chk("stray_d_valid", {31'd0, d_valid}, 32'd0);
    chk("stray_mem_req", {31'd0, mem_req}, 32'd0);

    // Contention: fetch held while five loads arrive back to back
    if_req = 1'b1; if_addr = 32'h0000_0200;
    d_rd_en = 1'b1; d_addr = 32'h0000_1000; d_type = 3'b010;
    li = 0;
    for (int g = 0; g < 6; g++) begin
      is_f = (g == 4);
      exp_addr = is_f ? 32'h0000_0200 : (32'h0000_1000 + 32'(li) * 32'd4);
      @(negedge clk);
      chk($sformatf("c%0d_mem_req", g), {31'd0, mem_req}, 32'd1);
      chk($sformatf("c%0d_grant_addr", g), mem_addr, exp_addr);
      chk($sformatf("c%0d_fetch_wait", g), {28'd0, dut.r_fetch_wait},
          is_f ? 32'd0 : ((g < 4) ? 32'(li + 1) : 32'd0));
      mem_ack = 1'b1;
      mem_rdata = is_f ? 32'h0000_0013 : (32'hA000_0000 + 32'(li));
      @(negedge clk);
      mem_ack = 1'b0;
      if (is_f) begin
        chk("c_if_valid", {31'd0, if_valid}, 32'd1);
        chk("c_if_rdata", if_rdata, 32'h0000_0013);
        if_req = 1'b0;
      end else begin
        chk($sformatf("c%0d_d_valid", g), {31'd0, d_valid}, 32'd1);
        chk($sformatf("c%0d_d_rdata", g), d_rdata, 32'hA000_0000 + 32'(li));
        li++;
        if (li < 5) d_addr = 32'h0000_1000 + 32'(li) * 32'd4;
        else d_rd_en = 1'b0;
      end
    end
    @(negedge clk);
    chk("c_idle_mem_req", {31'd0, mem_req}, 32'd0);
    chk("c_fetch_wait_end", {28'd0, dut.r_fetch_wait}, 32'd0);

    // Store with a three-cycle memory latency
    d_wr_en = 1'b1; d_addr = 32'h0000_0040; d_wdata = 32'hDEAD_BEEF; d_type = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("s%0d_mem_req", i), {31'd0, mem_req}, 32'd1);
      chk($sformatf("s%0d_mem_we", i), {31'd0, mem_we}, 32'd1);
      chk($sformatf("s%0d_mem_addr", i), mem_addr, 32'h0000_0040);
      chk($sformatf("s%0d_mem_wdata", i), mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("s%0d_mem_type", i), {29'd0, mem_type}, 32'd2);
      chk($sformatf("s%0d_d_valid", i), {31'd0, d_valid}, 32'd0);
      if (i == 2) begin
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    chk("s_d_valid", {31'd0, d_valid}, 32'd1);
    chk("s_d_rdata_hold", d_rdata, 32'hA000_0004);
    chk("s_mem_we_idle", {31'd0, mem_we}, 32'd0);
    d_wr_en = 1'b0;
    @(negedge clk);

    // Reset two cycles into a load
    d_rd_en = 1'b1; d_addr = 32'h0000_0080;
    @(negedge clk);
    chk("r_mem_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("r_async_mem_req", {31'd0, mem_req}, 32'd0);
    chk("r_async_mem_addr", mem_addr, 32'd0);
    chk("r_async_d_rdata", d_rdata, 32'd0);
    chk("r_async_if_rdata", if_rdata, 32'd0);
    chk("r_async_stall", {31'd0, cpu_stall}, 32'd0);
    d_rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("r_no_d_valid", {31'd0, d_valid}, 32'd0);
    chk("r_state_idle", 32'(dut.r_state), 32'd0);

    // Fetch that memory never acknowledges
    if_req = 1'b1; if_addr = 32'h0000_0300;
    @(negedge clk);
`ifdef ARB_TIMEOUT_EN
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("t_req_cycles", 32'(cnt), 32'd16);
    chk("t_if_valid", {31'd0, if_valid}, 32'd1);
    chk("t_bus_err", {31'd0, bus_err}, 32'd1);
    chk("t_if_rdata_hold", if_rdata, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    chk("t_bus_err_end", {31'd0, bus_err}, 32'd0);
`else
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req === 1'b1 && bus_err === 1'b0) cnt++;
      @(negedge clk);
    end
    chk("t_req_held", 32'(cnt), 32'd30);
    chk("t_no_bus_err", {31'd0, bus_err}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0777;
    @(negedge clk);
    mem_ack = 1'b0;
    if_req = 1'b0;
    chk("t_late_valid", {31'd0, if_valid}, 32'd1);
    chk("t_late_rdata", if_rdata, 32'h0000_0777);
    chk("t_late_bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
